// File: rtl/affine_seq.sv
// -----------------------------------------------------------------------------
// affine_seq
//   Multi-cycle controller that drives the shared signed ALU to compute one
//   2-D affine transform per request:
//       x' = a11*x + a12*y + b1
//       y' = a21*x + a22*y + b2
//   Coefficients are Q1.(N-1) fractions; coordinates and offsets are integers.
//   The multiply scaling and the add wrap-around are done inside the ALU; this
//   block only sequences operands and captures results.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_start        request pulse, sampled only while idle
//   i_x, i_y       signed point coordinates
//   i_a11..i_a22   signed fractional coefficients
//   i_b1, i_b2     signed integer offsets
//   o_alu_a/_b     ALU operands
//   o_alu_func     ALU function code
//   i_alu_result   ALU combinational result
//   o_x_out/_y_out registered transform results (held between transforms)
//   o_busy         high while a transform is in progress
//   o_done         one-cycle completion pulse
// -----------------------------------------------------------------------------
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif
`ifndef ALU_CODE_SIZE
`define ALU_CODE_SIZE 3
`endif
`ifndef RB
`define RB 3'd1
`endif
`ifndef RADD
`define RADD 3'd2
`endif
`ifndef RMULT
`define RMULT 3'd4
`endif

module affine_seq #(
    parameter int N             = `DATA_BUS_SIZE,
    parameter int ALU_CODE_SIZE = `ALU_CODE_SIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [N-1:0]             i_x,
    input  logic [N-1:0]             i_y,
    input  logic [N-1:0]             i_a11,
    input  logic [N-1:0]             i_a12,
    input  logic [N-1:0]             i_a21,
    input  logic [N-1:0]             i_a22,
    input  logic [N-1:0]             i_b1,
    input  logic [N-1:0]             i_b2,
    output logic [N-1:0]             o_alu_a,
    output logic [N-1:0]             o_alu_b,
    output logic [ALU_CODE_SIZE-1:0] o_alu_func,
    input  logic [N-1:0]             i_alu_result,
    output logic [N-1:0]             o_x_out,
    output logic [N-1:0]             o_y_out,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [3:0] {
        IDLE, M11, M12, ADD1, B1, M21, M22, ADD2, B2
    } state_t;

    localparam logic [ALU_CODE_SIZE-1:0] FUNC_B    = ALU_CODE_SIZE'(`RB);
    localparam logic [ALU_CODE_SIZE-1:0] FUNC_ADD  = ALU_CODE_SIZE'(`RADD);
    localparam logic [ALU_CODE_SIZE-1:0] FUNC_MULT = ALU_CODE_SIZE'(`RMULT);

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;

    // Operand copies taken at acceptance; the live inputs may change afterwards.
    logic [N-1:0]   r_x, r_y, r_a11, r_a12, r_a21, r_a22, r_b1, r_b2;
    logic [N-1:0]   r_acc, r_tmp;
    logic [N-1:0]   r_x_out, r_y_out;
    logic           r_done;

    assign w_accept = (r_state == IDLE) && i_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and ALU operand selection; operands depend on state only.
    always_comb begin
        w_state_next = r_state;
        o_alu_func   = FUNC_B;
        o_alu_a      = '0;
        o_alu_b      = '0;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_next = M11;
            end
            M11: begin
                o_alu_func   = FUNC_MULT;
                o_alu_a      = r_a11;
                o_alu_b      = r_x;
                w_state_next = M12;
            end
            M12: begin
                o_alu_func   = FUNC_MULT;
                o_alu_a      = r_a12;
                o_alu_b      = r_y;
                w_state_next = ADD1;
            end
            ADD1: begin
                o_alu_func   = FUNC_ADD;
                o_alu_a      = r_acc;
                o_alu_b      = r_tmp;
                w_state_next = B1;
            end
            B1: begin
                o_alu_func   = FUNC_ADD;
                o_alu_a      = r_acc;
                o_alu_b      = r_b1;
                w_state_next = M21;
            end
            M21: begin
                o_alu_func   = FUNC_MULT;
                o_alu_a      = r_a21;
                o_alu_b      = r_x;
                w_state_next = M22;
            end
            M22: begin
                o_alu_func   = FUNC_MULT;
                o_alu_a      = r_a22;
                o_alu_b      = r_y;
                w_state_next = ADD2;
            end
            ADD2: begin
                o_alu_func   = FUNC_ADD;
                o_alu_a      = r_acc;
                o_alu_b      = r_tmp;
                w_state_next = B2;
            end
            B2: begin
                o_alu_func   = FUNC_ADD;
                o_alu_a      = r_acc;
                o_alu_b      = r_b2;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: the ALU result is captured at the end of every busy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_a11   <= '0;
            r_a12   <= '0;
            r_a21   <= '0;
            r_a22   <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
            r_acc   <= '0;
            r_tmp   <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == B2);
            if (w_accept) begin
                r_x   <= i_x;
                r_y   <= i_y;
                r_a11 <= i_a11;
                r_a12 <= i_a12;
                r_a21 <= i_a21;
                r_a22 <= i_a22;
                r_b1  <= i_b1;
                r_b2  <= i_b2;
            end
            case (r_state)
                M11, ADD1, M21, ADD2: r_acc   <= i_alu_result;
                M12, M22:             r_tmp   <= i_alu_result;
                B1:                   r_x_out <= i_alu_result;
                B2:                   r_y_out <= i_alu_result;
                default: ;
            endcase
        end
    end

    assign o_x_out = r_x_out;
    assign o_y_out = r_y_out;
    assign o_done  = r_done;
    assign o_busy  = (r_state != IDLE);

endmodule
